// File: rtl/fpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fpu_pkg : FP32 constants, RISC-V rounding modes and fflags bit positions
// Rev 1.0
// ---------------------------------------------------------------------------
package fpu_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rm_e;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
  localparam int          BIAS       = 127;
  localparam logic [9:0]  EXP_MAX    = 10'd255;
  localparam logic [30:0] MAX_FINITE = 31'h7F7F_FFFF;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] sig;
    logic        g;
    logic        r;
    logic        s;
    logic        tiny;
    logic        is_nan;
    logic        is_inf;
    logic        is_zero;
    logic        nv;
    rm_e         rm;
  } norm_t;

  function automatic logic round_inc(input rm_e rm, input logic sign, input logic lsb,
                                     input logic g, input logic r, input logic s);
    logic inc;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | r | s);
      RM_RUP:  inc = ~sign & (g | r | s);
      RM_RMM:  inc = g;
      default: inc = g & (r | s | lsb);
    endcase
    return inc;
  endfunction

  // Overflow saturates to infinity only when rounding moves away from zero.
  function automatic logic of_to_inf(input rm_e rm, input logic sign);
    return (rm == RM_RNE) || (rm == RM_RMM) || (rm == RM_RUP && !sign) || (rm == RM_RDN && sign);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc48.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_lzc48 : combinational 48-bit leading-zero count with all-zero flag
// Rev 1.0
// ---------------------------------------------------------------------------
module fp_lzc48 (
  input  logic [47:0] in,
  output logic [5:0]  count,
  output logic        zero
);

  always_comb begin
    count = 6'd48;
    for (int i = 0; i < 48; i++) begin
      if (in[i]) count = 6'(47 - i);
    end
    zero = (in == 48'd0);
  end

endmodule
`default_nettype wire

// File: rtl/fmul_round_pack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fmul_round_pack : FP32 multiplier back end - normalise, round, pack, fflags
// Rev 1.0
// ---------------------------------------------------------------------------
module fmul_round_pack
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [9:0]       in_exp,
  input  logic [47:0]      in_mant,
  input  logic [2:0]       in_cls,
  input  logic             in_nv,
  input  logic [2:0]       in_rm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_flags,
  output logic [4:0]       fflags,
  input  logic             flags_clr
);

  logic             s1_valid;
  logic             s2_load;
  logic             s1_adv;
  norm_t            s1_d;
  norm_t            s1_q;
  logic [TAG_W-1:0] s1_tag;

  assign s2_load  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_load;
  assign in_ready = !s1_valid || s1_adv;

  logic [5:0] lzc;
  logic       mant_zero;

  fp_lzc48 u_lzc (
    .in    (in_mant),
    .count (lzc),
    .zero  (mant_zero)
  );

  logic [11:0] e_unb;
  logic [11:0] sh_full;
  logic        tiny;
  logic [4:0]  sh;
  logic [47:0] norm;
  logic [47:0] denorm;
  logic        lost;

  // Stage 1: E = in_exp + p - 46 with p = 47 - lzc.
  always_comb begin
    e_unb   = {{2{in_exp[9]}}, in_exp} + 12'd1 - {6'd0, lzc};
    tiny    = e_unb[11] || (e_unb == 12'd0);
    sh_full = 12'd1 - e_unb;
    sh      = 5'd0;
    if (tiny) sh = (sh_full > 12'd26) ? 5'd26 : sh_full[4:0];
    norm    = in_mant << lzc;
    denorm  = norm >> sh;
    lost    = |(norm & ~({48{1'b1}} << sh));

    s1_d.sign    = in_sign;
    s1_d.exp     = tiny ? 10'd0 : e_unb[9:0];
    s1_d.sig     = denorm[47:24];
    s1_d.g       = denorm[23];
    s1_d.r       = denorm[22];
    s1_d.s       = (|denorm[21:0]) | lost;
    s1_d.tiny    = tiny;
    s1_d.is_nan  = in_cls[2];
    s1_d.is_inf  = in_cls[1];
    s1_d.is_zero = in_cls[0] | mant_zero;
    s1_d.nv      = in_nv;
    s1_d.rm      = (in_rm > 3'd4) ? RM_RNE : rm_e'(in_rm);
  end

  logic        inc;
  logic        nx;
  logic        of;
  logic [24:0] rounded;
  logic [9:0]  fexp;
  logic [22:0] frac;
  logic [31:0] res_d;
  logic [4:0]  flags_d;

  // Stage 2: a subnormal whose rounding carries into bit 23 picks up exponent 1.
  always_comb begin
    inc     = round_inc(s1_q.rm, s1_q.sign, s1_q.sig[0], s1_q.g, s1_q.r, s1_q.s);
    rounded = {1'b0, s1_q.sig} + {24'd0, inc};
    fexp    = s1_q.tiny ? {9'd0, rounded[23]} : (s1_q.exp + {9'd0, rounded[24]});
    frac    = rounded[24] ? rounded[23:1] : rounded[22:0];
    nx      = s1_q.g | s1_q.r | s1_q.s;
    of      = (fexp >= EXP_MAX);

    flags_d          = 5'd0;
    flags_d[FLAG_NV] = s1_q.nv;
    if (s1_q.is_nan) begin
      res_d = CANON_NAN;
    end else if (s1_q.is_inf) begin
      res_d = {s1_q.sign, 8'hFF, 23'd0};
    end else if (s1_q.is_zero) begin
      res_d = {s1_q.sign, 31'd0};
    end else if (of) begin
      res_d = of_to_inf(s1_q.rm, s1_q.sign) ? {s1_q.sign, 8'hFF, 23'd0} : {s1_q.sign, MAX_FINITE};
      flags_d[FLAG_OF] = 1'b1;
      flags_d[FLAG_NX] = 1'b1;
    end else begin
      res_d = {s1_q.sign, fexp[7:0], frac};
      flags_d[FLAG_UF] = s1_q.tiny & nx;
      flags_d[FLAG_NX] = nx;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      fflags    <= 5'd0;
    end else begin
      if (in_ready) s1_valid  <= in_valid;
      if (s2_load)  out_valid <= s1_valid;
      if (flags_clr)
        fflags <= (out_valid && out_ready) ? out_flags : 5'd0;
      else if (out_valid && out_ready)
        fflags <= fflags | out_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_q   <= s1_d;
      s1_tag <= in_tag;
    end
    if (s1_adv) begin
      out_result <= res_d;
      out_tag    <= s1_tag;
      out_flags  <= flags_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fmul_round_pack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fmul_round_pack : directed self-checking bench for fmul_round_pack
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_fmul_round_pack;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic [2:0]  in_cls;
  logic        in_nv;
  logic [2:0]  in_rm;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic [4:0]  out_flags;
  logic [4:0]  fflags;
  logic        flags_clr;

  int          checks = 0;
  int          errors = 0;
  logic [4:0]  exp_ff = 5'd0;

  fmul_round_pack #(.TAG_W(5)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_cls     (in_cls),
    .in_nv      (in_nv),
    .in_rm      (in_rm),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_flags  (out_flags),
    .fflags     (fflags),
    .flags_clr  (flags_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic sg, input logic [9:0] ex, input logic [47:0] mt,
                       input logic [2:0] cl, input logic nv, input logic [2:0] rm,
                       input logic [4:0] tg);
    in_sign = sg; in_exp = ex; in_mant = mt; in_cls = cl; in_nv = nv; in_rm = rm; in_tag = tg;
  endtask

  task automatic do_op(input string nm, input logic sg, input logic [9:0] ex,
                       input logic [47:0] mt, input logic [2:0] cl, input logic nv,
                       input logic [2:0] rm, input logic [4:0] tg,
                       input logic [31:0] er, input logic [4:0] ef, input logic clr);
    int lat;
    @(negedge clk);
    drive(sg, ex, mt, cl, nv, rm, tg);
    in_valid = 1'b1;
    chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    chk({nm, " latency"}, 32'(lat), 32'd2);
    chk({nm, " result"}, out_result, er);
    chk({nm, " flags"}, 32'(out_flags), 32'(ef));
    chk({nm, " tag"}, 32'(out_tag), 32'(tg));
    exp_ff    = clr ? ef : (exp_ff | ef);
    flags_clr = clr;
    @(negedge clk);
    flags_clr = 1'b0;
    chk({nm, " fflags"}, 32'(fflags), 32'(exp_ff));
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flags_clr = 1'b0;
    drive(1'b0, 10'd0, 48'd0, 3'd0, 1'b0, 3'd0, 5'd0);
    repeat (2) @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset fflags", 32'(fflags), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    resetn = 1'b1;

    // name, sign, exp, mant, cls, nv, rm, tag, result, flags, clr
    do_op("normal",       1'b0, 10'd127, 48'h9000_0000_0000, 3'b000, 1'b0, 3'd0, 5'd1,  32'h4010_0000, 5'b00000, 1'b0);
    do_op("tie_rne_up",   1'b0, 10'd127, 48'h8000_0180_0000, 3'b000, 1'b0, 3'd0, 5'd2,  32'h4000_0002, 5'b00001, 1'b0);
    do_op("tie_rtz",      1'b0, 10'd127, 48'h8000_0180_0000, 3'b000, 1'b0, 3'd1, 5'd3,  32'h4000_0001, 5'b00001, 1'b0);
    do_op("tie_rne_even", 1'b0, 10'd127, 48'h8000_0080_0000, 3'b000, 1'b0, 3'd0, 5'd4,  32'h4000_0000, 5'b00001, 1'b0);
    do_op("tie_rmm",      1'b0, 10'd127, 48'h8000_0080_0000, 3'b000, 1'b0, 3'd4, 5'd5,  32'h4000_0001, 5'b00001, 1'b0);
    do_op("rup_pos",      1'b0, 10'd127, 48'h8000_0080_0000, 3'b000, 1'b0, 3'd3, 5'd6,  32'h4000_0001, 5'b00001, 1'b0);
    do_op("rdn_pos",      1'b0, 10'd127, 48'h8000_0080_0000, 3'b000, 1'b0, 3'd2, 5'd7,  32'h4000_0000, 5'b00001, 1'b0);
    do_op("rdn_neg",      1'b1, 10'd127, 48'h8000_0080_0000, 3'b000, 1'b0, 3'd2, 5'd8,  32'hC000_0001, 5'b00001, 1'b0);
    do_op("rm_reserved",  1'b0, 10'd127, 48'h8000_0180_0000, 3'b000, 1'b0, 3'd7, 5'd9,  32'h4000_0002, 5'b00001, 1'b0);
    do_op("of_rne",       1'b0, 10'd300, 48'h4000_0000_0000, 3'b000, 1'b0, 3'd0, 5'd10, 32'h7F80_0000, 5'b00101, 1'b0);
    do_op("of_rtz",       1'b0, 10'd300, 48'h4000_0000_0000, 3'b000, 1'b0, 3'd1, 5'd11, 32'h7F7F_FFFF, 5'b00101, 1'b0);
    do_op("of_rdn_neg",   1'b1, 10'd300, 48'h4000_0000_0000, 3'b000, 1'b0, 3'd2, 5'd12, 32'hFF80_0000, 5'b00101, 1'b0);
    do_op("of_rup_neg",   1'b1, 10'd300, 48'h4000_0000_0000, 3'b000, 1'b0, 3'd3, 5'd13, 32'hFF7F_FFFF, 5'b00101, 1'b0);
    do_op("of_carry",     1'b0, 10'd253, 48'hFFFF_FF80_0000, 3'b000, 1'b0, 3'd0, 5'd14, 32'h7F80_0000, 5'b00101, 1'b0);
    do_op("uf_inexact",   1'b0, 10'h3EC, 48'h4000_0000_0001, 3'b000, 1'b0, 3'd0, 5'd15, 32'h0000_0004, 5'b00011, 1'b0);
    do_op("uf_exact",     1'b0, 10'h3EC, 48'h4000_0000_0000, 3'b000, 1'b0, 3'd0, 5'd16, 32'h0000_0004, 5'b00000, 1'b0);
    do_op("sub_to_norm",  1'b0, 10'h3FF, 48'hFFFF_FFFF_FFFF, 3'b000, 1'b0, 3'd0, 5'd17, 32'h0080_0000, 5'b00011, 1'b0);
    do_op("uf_cap_rup",   1'b0, 10'h2D4, 48'h4000_0000_0000, 3'b000, 1'b0, 3'd3, 5'd18, 32'h0000_0001, 5'b00011, 1'b0);
    do_op("uf_cap_rne",   1'b0, 10'h2D4, 48'h4000_0000_0000, 3'b000, 1'b0, 3'd0, 5'd19, 32'h0000_0000, 5'b00011, 1'b0);
    do_op("nv_normal",    1'b0, 10'd127, 48'h9000_0000_0000, 3'b000, 1'b1, 3'd0, 5'd20, 32'h4010_0000, 5'b10000, 1'b0);
    do_op("nan",          1'b0, 10'd127, 48'h9000_0000_0000, 3'b100, 1'b1, 3'd0, 5'd21, 32'h7FC0_0000, 5'b10000, 1'b0);
    do_op("inf_over_zero",1'b1, 10'd127, 48'h9000_0000_0000, 3'b011, 1'b0, 3'd0, 5'd22, 32'hFF80_0000, 5'b00000, 1'b0);
    do_op("zero_cls",     1'b1, 10'd127, 48'h9000_0000_0000, 3'b001, 1'b0, 3'd0, 5'd23, 32'h8000_0000, 5'b00000, 1'b0);
    do_op("mant_zero",    1'b0, 10'd127, 48'h0000_0000_0000, 3'b000, 1'b0, 3'd0, 5'd24, 32'h0000_0000, 5'b00000, 1'b0);
    do_op("clr_on_hs",    1'b0, 10'd127, 48'h8000_0180_0000, 3'b000, 1'b0, 3'd0, 5'd25, 32'h4000_0002, 5'b00001, 1'b1);

    // Standalone clear of the sticky flags.
    @(negedge clk);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    exp_ff = 5'd0;
    chk("flags_clr alone", 32'(fflags), 32'd0);

    // Backpressure: three back-to-back inputs, writeback stalled.
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b0, 10'd127, 48'h9000_0000_0000, 3'b000, 1'b0, 3'd0, 5'd1);
    in_valid = 1'b1;
    chk("bp in_ready A", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 10'd127, 48'h8000_0000_0000, 3'b000, 1'b0, 3'd0, 5'd2);
    chk("bp in_ready B", 32'(in_ready), 32'd1);
    @(negedge clk);
    drive(1'b0, 10'd126, 48'h8000_0000_0000, 3'b000, 1'b0, 3'd0, 5'd3);
    chk("bp in_ready drop", 32'(in_ready), 32'd0);
    chk("bp out_valid", 32'(out_valid), 32'd1);
    chk("bp tag A", 32'(out_tag), 32'd1);
    repeat (3) @(negedge clk);
    chk("bp hold in_ready", 32'(in_ready), 32'd0);
    chk("bp hold tag", 32'(out_tag), 32'd1);
    chk("bp hold result", out_result, 32'h4010_0000);
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp out_valid B", 32'(out_valid), 32'd1);
    chk("bp tag B", 32'(out_tag), 32'd2);
    chk("bp result B", out_result, 32'h4000_0000);
    @(negedge clk);
    chk("bp out_valid C", 32'(out_valid), 32'd1);
    chk("bp tag C", 32'(out_tag), 32'd3);
    chk("bp result C", out_result, 32'h3F80_0000);
    @(negedge clk);
    chk("bp drained", 32'(out_valid), 32'd0);

    do_op("pre_reset", 1'b0, 10'd127, 48'h8000_0180_0000, 3'b000, 1'b0, 3'd0, 5'd26, 32'h4000_0002, 5'b00001, 1'b0);

    // Asynchronous reset with two operations in flight.
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b0, 10'd127, 48'h9000_0000_0000, 3'b000, 1'b0, 3'd0, 5'd27);
    in_valid = 1'b1;
    @(negedge clk);
    drive(1'b0, 10'd127, 48'h8000_0000_0000, 3'b000, 1'b0, 3'd0, 5'd28);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst pre out_valid", 32'(out_valid), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("rst async out_valid", 32'(out_valid), 32'd0);
    chk("rst async in_ready", 32'(in_ready), 32'd1);
    chk("rst async fflags", 32'(fflags), 32'd0);
    exp_ff = 5'd0;
    @(negedge clk);
    resetn = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst no ghost", 32'(out_valid), 32'd0);

    do_op("post_reset", 1'b0, 10'd127, 48'h9000_0000_0000, 3'b000, 1'b0, 3'd0, 5'd29, 32'h4010_0000, 5'b00000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
